// File: rtl/uart_tx_serializer_if.sv
// Handshake/bus bundle for the UART TX serializer.
//   baud_clk : divider baud clock (async-grade, one rising edge per bit)
//   data_in  : byte to send, sampled only when a request is accepted
//   start    : level send request, accepted only while idle
//   tx       : serial line, idles high
//   busy     : high from accept until frame end
//   done     : one-cycle pulse at frame end
interface uart_tx_serializer_if;
  logic       baud_clk;
  logic [7:0] data_in;
  logic       start;
  logic       tx;
  logic       busy;
  logic       done;

  modport master (output baud_clk, data_in, start, input tx, busy, done);
  modport slave  (input baud_clk, data_in, start, output tx, busy, done);
endinterface

// File: rtl/uart_tx_serializer.sv
// UART transmit serializer. Synchronizes the divider's baud clock into the
// clk_in domain, turns each rising edge into a one-cycle tick and shifts one
// frame (start, 8 data LSB first, optional parity, 1 or 2 stop bits) per
// accepted request.
//   clk_in : system clock
//   rst    : asynchronous active-low reset
//   bus    : slave side of uart_tx_serializer_if (baud_clk/data_in/start in,
//            tx/busy/done out)
module uart_tx_serializer #(
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0,
  parameter int STOP_BITS  = 1
) (
  input  logic                 clk_in,
  input  logic                 rst,
  uart_tx_serializer_if.slave  bus
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    ALIGN  = 3'd1,
    START  = 3'd2,
    DATA   = 3'd3,
    PARITY = 3'd4,
    STOP   = 3'd5
  } state_t;

  localparam logic [1:0] STOP_LAST = 2'(STOP_BITS - 1);
  localparam logic       PAR_INIT  = (PARITY_ODD != 0);

  logic       r_sync1, r_sync2, r_prev;
  logic       w_tick;

  state_t     r_state,    w_state_nx;
  logic [7:0] r_shift,    w_shift_nx;
  logic [2:0] r_bit_cnt,  w_bit_cnt_nx;
  logic [1:0] r_stop_cnt, w_stop_cnt_nx;
  logic       r_par,      w_par_nx;
  logic       r_tx,       w_tx_nx;
  logic       r_busy,     w_busy_nx;
  logic       r_done,     w_done_nx;

  // Two-flop synchronizer plus a history flop for rising-edge detection.
  always_ff @(posedge clk_in or negedge rst) begin
    if (!rst) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_prev  <= 1'b0;
    end else begin
      r_sync1 <= bus.baud_clk;
      r_sync2 <= r_sync1;
      r_prev  <= r_sync2;
    end
  end

  assign w_tick = r_sync2 & ~r_prev;

  always_ff @(posedge clk_in or negedge rst) begin
    if (!rst) begin
      r_state    <= IDLE;
      r_shift    <= 8'h00;
      r_bit_cnt  <= 3'd0;
      r_stop_cnt <= 2'd0;
      r_par      <= 1'b0;
      r_tx       <= 1'b1;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_state    <= w_state_nx;
      r_shift    <= w_shift_nx;
      r_bit_cnt  <= w_bit_cnt_nx;
      r_stop_cnt <= w_stop_cnt_nx;
      r_par      <= w_par_nx;
      r_tx       <= w_tx_nx;
      r_busy     <= w_busy_nx;
      r_done     <= w_done_nx;
    end
  end

  always_comb begin
    w_state_nx    = r_state;
    w_shift_nx    = r_shift;
    w_bit_cnt_nx  = r_bit_cnt;
    w_stop_cnt_nx = r_stop_cnt;
    w_par_nx      = r_par;
    w_tx_nx       = r_tx;
    w_busy_nx     = r_busy;
    w_done_nx     = 1'b0;

    unique case (r_state)
      IDLE: begin
        w_tx_nx = 1'b1;
        if (bus.start) begin
          w_shift_nx = bus.data_in;
          // Parity is fixed at accept so the shifter can destroy the byte.
          w_par_nx   = (^bus.data_in) ^ PAR_INIT;
          w_busy_nx  = 1'b1;
          w_state_nx = ALIGN;
        end
      end
      // Wait for a fresh tick so the start bit is a full bit period wide.
      ALIGN: begin
        if (w_tick) begin
          w_tx_nx    = 1'b0;
          w_state_nx = START;
        end
      end
      START: begin
        if (w_tick) begin
          w_tx_nx      = r_shift[0];
          w_bit_cnt_nx = 3'd0;
          w_state_nx   = DATA;
        end
      end
      DATA: begin
        if (w_tick) begin
          if (r_bit_cnt != 3'd7) begin
            w_shift_nx   = {1'b0, r_shift[7:1]};
            w_tx_nx      = r_shift[1];
            w_bit_cnt_nx = r_bit_cnt + 3'd1;
          end else begin
            w_stop_cnt_nx = 2'd0;
            if (PARITY_EN != 0) begin
              w_tx_nx    = r_par;
              w_state_nx = PARITY;
            end else begin
              w_tx_nx    = 1'b1;
              w_state_nx = STOP;
            end
          end
        end
      end
      PARITY: begin
        if (w_tick) begin
          w_tx_nx       = 1'b1;
          w_stop_cnt_nx = 2'd0;
          w_state_nx    = STOP;
        end
      end
      STOP: begin
        w_tx_nx = 1'b1;
        if (w_tick) begin
          if (r_stop_cnt == STOP_LAST) begin
            w_busy_nx     = 1'b0;
            w_done_nx     = 1'b1;
            w_stop_cnt_nx = 2'd0;
            w_state_nx    = IDLE;
          end else begin
            w_stop_cnt_nx = r_stop_cnt + 2'd1;
          end
        end
      end
      default: begin
        w_tx_nx    = 1'b1;
        w_busy_nx  = 1'b0;
        w_state_nx = IDLE;
      end
    endcase
  end

  assign bus.tx   = r_tx;
  assign bus.busy = r_busy;
  assign bus.done = r_done;

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Self-checking bench: four serializer configurations share one stimulus;
// a monitor samples each tx line mid-bit and compares completed frames
// against frames built from the framing rules.
module tb_uart_tx_serializer;
  localparam int NUM = 4;
  localparam int PE [NUM] = '{0, 1, 1, 0};
  localparam int PO [NUM] = '{0, 0, 1, 0};
  localparam int SB [NUM] = '{1, 1, 1, 2};

  typedef struct packed {
    logic [15:0] bits;
    logic [7:0]  len;
  } frm_t;

  logic           clk, rst, baud, start, freeze;
  logic [7:0]     data;
  logic [NUM-1:0] tx_v, busy_v, done_v;
  int             total, bad;

  frm_t           exp_q [NUM][$];
  logic [15:0]    col [NUM];
  int             col_n [NUM];
  bit             started [NUM];
  logic [NUM-1:0] busy_p, done_p, tx_p;
  logic           baud_p;
  int             since;
  bit             rst_p;

  for (genvar k = 0; k < NUM; k++) begin : g_dut
    uart_tx_serializer_if ifc ();
    assign ifc.baud_clk = baud;
    assign ifc.data_in  = data;
    assign ifc.start    = start;
    assign tx_v[k]      = ifc.tx;
    assign busy_v[k]    = ifc.busy;
    assign done_v[k]    = ifc.done;
    uart_tx_serializer #(.PARITY_EN(PE[k]), .PARITY_ODD(PO[k]), .STOP_BITS(SB[k])) u_dut (
      .clk_in (clk),
      .rst    (rst),
      .bus    (ifc.slave)
    );
  end

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // 16-cycle baud period, edges placed just after a falling clk edge.
  initial begin
    baud = 1'b0;
    forever begin
      repeat (8) @(negedge clk);
      #1;
      if (!freeze) baud = ~baud;
    end
  end

  task automatic chk(input string nm, input int k, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s dut%0d actual=%0h expected=%0h t=%0t", nm, k, act, exp, $time);
    end
  endtask

  // Reference frame: start 0, data LSB first, optional parity, stop 1s.
  function automatic frm_t model(input logic [7:0] b, input int k);
    frm_t f;
    int   n;
    f.bits = '0;
    n = 0;
    f.bits[n] = 1'b0; n++;
    for (int j = 0; j < 8; j++) begin f.bits[n] = b[j]; n++; end
    if (PE[k] != 0) begin f.bits[n] = (^b) ^ (PO[k] != 0); n++; end
    for (int j = 0; j < SB[k]; j++) begin f.bits[n] = 1'b1; n++; end
    f.len = 8'(n);
    return f;
  endfunction

  task automatic mon_step();
    frm_t        f;
    logic [15:0] m;
    if (!rst) begin
      for (int k = 0; k < NUM; k++) begin
        col[k] = '0; col_n[k] = 0; started[k] = 0;
        exp_q[k].delete();
      end
      busy_p = '0; done_p = '0; tx_p = tx_v; baud_p = baud;
      since = 100; rst_p = 0;
    end else begin
      if (baud && !baud_p) since = 0;
      else if (since < 100) since++;
      baud_p = baud;
      for (int k = 0; k < NUM; k++) begin
        if (busy_v[k] && !busy_p[k]) begin
          exp_q[k].push_back(model(data, k));
          col[k] = '0; col_n[k] = 0; started[k] = 0;
        end
        // tx may only move on the third clk edge after a baud rise.
        if (rst_p && tx_v[k] !== tx_p[k]) chk("tx_edge_phase", k, 32'(since), 32'd2);
        if (since == 6 && busy_v[k] && (started[k] || tx_v[k] == 1'b0)) begin
          started[k] = 1;
          if (col_n[k] < 16) col[k][col_n[k]] = tx_v[k];
          col_n[k]++;
        end
        if (done_v[k]) begin
          chk("done_busy_fall", k, 32'({busy_p[k], busy_v[k]}), 32'd2);
          chk("done_width", k, 32'(done_p[k]), 32'd0);
          chk("done_has_exp", k, 32'(exp_q[k].size() > 0), 32'd1);
          if (exp_q[k].size() > 0) begin
            f = exp_q[k].pop_front();
            m = 16'((32'd1 << f.len) - 32'd1);
            chk("frame_len", k, 32'(col_n[k]), 32'(f.len));
            chk("frame_bits", k, 32'(col[k] & m), 32'(f.bits));
          end
        end
      end
      busy_p = busy_v; done_p = done_v; tx_p = tx_v; rst_p = 1;
    end
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    do begin @(negedge clk); n++; end while (busy_v != '0 && n < 3000);
    chk("idle_reached", 0, 32'(busy_v), 32'd0);
    repeat (2) @(negedge clk);
  endtask

  task automatic pulse_start();
    @(negedge clk); #1 start = 1'b1;
    @(negedge clk); #1 start = 1'b0;
  endtask

  task automatic send(input logic [7:0] b);
    data = b;
    repeat ($urandom_range(0, 20)) @(negedge clk);
    pulse_start();
    wait_idle();
  endtask

  // Start a frame in the low baud phase so the next rise is its first tick.
  task automatic start_aligned(input logic [7:0] b);
    data = b;
    @(posedge baud);
    repeat (8) @(negedge clk);
    #1 start = 1'b1;
    @(negedge clk);
    #1 start = 1'b0;
  endtask

  initial begin
    logic [7:0]     b;
    logic [NUM-1:0] gd, rd, txbad, dn;
    int             n;
    total = 0; bad = 0;
    rst = 1'b0; start = 1'b0; data = 8'h00; freeze = 1'b0;
    #23;
    for (int k = 0; k < NUM; k++) begin
      chk("rst_tx", k, 32'(tx_v[k]), 32'd1);
      chk("rst_busy", k, 32'(busy_v[k]), 32'd0);
      chk("rst_done", k, 32'(done_v[k]), 32'd0);
    end
    @(negedge clk); #1 rst = 1'b1;

    fork
      forever begin @(negedge clk); mon_step(); end
      begin
        send(8'h55);
        send(8'hA3);
        send(8'hFF);
        for (int r = 0; r < 6; r++) send(8'($urandom));

        // Held start with data changing mid-frame.
        data = 8'h3C;
        @(negedge clk); #1 start = 1'b1;
        n = 0;
        do begin @(negedge clk); n++; end while (busy_v != '1 && n < 50);
        chk("held_accept", 0, 32'(busy_v), 32'(4'hF));
        #2 data = 8'h00;
        gd = '0; rd = '0; n = 0;
        while (rd != '1 && n < 1000) begin
          @(negedge clk); n++;
          for (int k = 0; k < NUM; k++) begin
            if (done_v[k]) gd[k] = 1'b1;
            else if (gd[k] && busy_v[k]) rd[k] = 1'b1;
          end
        end
        chk("held_second_accept", 0, 32'(rd), 32'(4'hF));
        #1 start = 1'b0;
        wait_idle();

        // Baud clock frozen high mid-DATA: line must hold D3.
        b = 8'($urandom);
        start_aligned(b);
        repeat (5) @(posedge baud);
        repeat (4) @(negedge clk);
        freeze = 1'b1;
        repeat (200) @(negedge clk);
        for (int k = 0; k < NUM; k++) begin
          chk("stall_tx", k, 32'(tx_v[k]), 32'(b[3]));
          chk("stall_busy", k, 32'(busy_v[k]), 32'd1);
        end
        freeze = 1'b0;
        wait_idle();

        // Asynchronous reset during D3 (D3 = 0 so the line visibly returns high).
        b = 8'($urandom) & 8'hF7;
        start_aligned(b);
        repeat (5) @(posedge baud);
        repeat (8) @(negedge clk);
        #2 rst = 1'b0;
        #1;
        for (int k = 0; k < NUM; k++) begin
          chk("async_rst_tx", k, 32'(tx_v[k]), 32'd1);
          chk("async_rst_busy", k, 32'(busy_v[k]), 32'd0);
        end
        repeat (3) @(negedge clk);
        #1 rst = 1'b1;
        txbad = '0; dn = '0;
        repeat (100) begin
          @(negedge clk);
          for (int k = 0; k < NUM; k++) begin
            if (tx_v[k] !== 1'b1) txbad[k] = 1'b1;
            if (done_v[k] !== 1'b0) dn[k] = 1'b1;
          end
        end
        for (int k = 0; k < NUM; k++) begin
          chk("post_rst_tx_low", k, 32'(txbad[k]), 32'd0);
          chk("post_rst_done", k, 32'(dn[k]), 32'd0);
        end

        send(8'($urandom));
        wait_idle();
        for (int k = 0; k < NUM; k++) chk("queue_empty", k, 32'(exp_q[k].size()), 32'd0);
      end
    join_any
    disable fork;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/uart_tx_serializer.md
Name: uart_tx_serializer

Overview:
- Serial transmitter stage directly downstream of the baud clock divider. It consumes the divider's square-wave baud clock in the clk_in domain and serializes one byte per request onto the TX line.
- Frame format: 8N1 by default. Parity and 2 stop bits are selectable by parameter.
- Raises busy during the frame and pulses done at frame end. The Nios-side control logic uses done to launch the next byte.

Parameters:
- PARITY_EN, 0, 1 = insert a parity bit after D7; 0 = no parity bit.
- PARITY_ODD, 0, 1 = odd parity; 0 = even parity. Ignored when PARITY_EN = 0.
- STOP_BITS, 1, number of stop bits. Legal values are 1 or 2.

Ports:
- clk_in  input  1  system clock; the only clock in the block.
- rst  input  1  asynchronous, active-low reset.
- baud_clk  input  1  divider baud clock output. Asynchronous-grade input; one rising edge per bit period.
- data_in  input  8  byte to send; sampled only on accept.
- start  input  1  send request; level-sensitive and qualified by busy = 0.
- tx  output  1  serial line; idles high.
- busy  output  1  high from accept until the frame ends.
- done  output  1  one clk_in cycle pulse at frame end.

Behaviour:
- Reset: rst low forces the following immediately, without waiting for a clock edge, including mid-frame:
  - tx = 1, busy = 0, done = 0
  - state = IDLE, shift register = 0, bit counter = 0, stop counter = 0
  - synchronizer flops = 0
- baud_clk is synchronized through 2 flops, then a third flop holds the previous value. tick = sync2 & ~prev, one clk_in cycle wide per baud_clk rising edge.
- tx, busy and done are registered. A tx change occurs on the clk_in edge where tick is high, i.e. 3 clk_in edges after baud_clk rises.
- States (all bit transitions happen only on tick):
  - IDLE: tx = 1. If start = 1, latch data_in into the shift register, set busy = 1 on the same edge, go to ALIGN.
  - ALIGN: wait for the first tick. On tick, tx = 0 (start bit), go to START. This guarantees a full-width start bit.
  - START: on tick, tx = D0, bit counter = 0, go to DATA.
  - DATA: on tick, if counter < 7, shift, tx = next bit (LSB first), counter + 1. When counter = 7:
    - PARITY_EN = 1: tx = parity, go to PARITY. Parity bit = XOR(D7..D0) XOR PARITY_ODD.
    - PARITY_EN = 0: tx = 1, go to STOP.
  - PARITY: on tick, tx = 1, go to STOP.
  - STOP: tx held at 1. Each tick increments the stop counter. On the STOP_BITS-th tick: busy = 0, done = 1 for one cycle, go to IDLE.
- A new start may be accepted in the cycle after done. Back-to-back frames therefore have no idle gap beyond ALIGN.
- start while busy = 1 is ignored, and data_in changes during a frame are ignored.
- If baud_clk stalls (divider reconfiguring), the FSM holds its state and tx level indefinitely; there is no timeout.
- A baud_clk rate change mid-frame is legal: remaining bits use the new period. Upper logic is responsible for only reconfiguring while busy = 0.
- Requirement: the baud_clk high and low phases must each last at least 2 clk_in cycles. Narrower pulses may be missed, which is legal misuse.
- Frame length from first tick to done: (1 + 8 + PARITY_EN + STOP_BITS) ticks.

Test Plan:
- Setup for all cases: baud_clk period 16 clk_in cycles.
- Defaults, data_in = 0x55, start pulse → tx = 0 | 1,0,1,0,1,0,1,0 | 1, each bit 16 cycles. busy high throughout; done is one cycle, coincident with busy falling; 10 ticks from first tick to done.
- PARITY_EN = 1, PARITY_ODD = 0, data_in = 0xA3 → data bits 1,1,0,0,0,1,0,1, parity bit 0. With PARITY_ODD = 1, parity bit 1; 11 ticks total.
- STOP_BITS = 2, data_in = 0xFF → stop high lasts 32 cycles before done; tx never glitches low after the start bit.
- start held high, data_in changed to 0x00 mid-frame → the first frame sends the original byte. A second frame with 0x00 starts after done; no start is accepted while busy.
- rst driven low during D3 of a frame → tx = 1 and busy = 0 immediately (asynchronously). After release with start = 0, tx stays high and done never asserts.
- baud_clk frozen high for 200 cycles mid-DATA → tx and bit counter hold. On resume, the frame completes with correct bits and a single done.
